// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared loader states, header length and checksum width
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam int HDR_BYTES = 2;
  localparam int LEN_W     = 8 * HDR_BYTES;
  localparam int CHK_W     = 8;

  // States in which the loader consumes stream bytes; also the busy window.
  function automatic logic accepts_bytes(input state_e s);
    return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK};
  endfunction

  function automatic logic [CHK_W-1:0] chk_update(input logic [CHK_W-1:0] c,
                                                  input logic [7:0]       b);
    return c ^ b;
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// rtl/prog_loader_word_assembler.sv - big-endian byte-to-word assembler with word-valid pulse
module word_assembler #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic [8*WORD_BYTES-1:0] word_out,
  output logic                    word_valid
);

  localparam int CNT_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int SHIFT_W = 8 * (WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  // The final byte completes the word combinationally so the caller can
  // register the write without losing a cycle of stream bandwidth.
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_valid = byte_valid && (cnt_q == LAST);
    word_out   = {shift_q, byte_in};
    if (clear) begin
      cnt_d = '0;
    end else if (byte_valid) begin
      cnt_d   = word_valid ? '0 : cnt_q + 1'b1;
      shift_d = SHIFT_W'({shift_q, byte_in});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a length-prefixed, XOR-checked program stream into instruction memory
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  output logic                  IM_WE,
  output logic [INST_WIDTH-1:0] IM_ADDR,
  output logic [INST_WIDTH-1:0] IM_WD,
  output logic                  CPU_RST_N,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam int BPW        = INST_WIDTH / 8;
  localparam int ADDR_SHIFT = $clog2(BPW);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      word_cnt_q, word_cnt_d;
  logic [CHK_W-1:0]      chk_q, chk_d;
  logic                  im_we_q, im_we_d;
  logic [INST_WIDTH-1:0] im_addr_q, im_addr_d;
  logic [INST_WIDTH-1:0] im_wd_q, im_wd_d;

  logic                  byte_fire;
  logic                  start_fire;
  logic                  asm_valid;
  logic                  asm_word_valid;
  logic [INST_WIDTH-1:0] asm_word;
  logic [LEN_W-1:0]      len_lo_val;

  assign BYTE_READY = accepts_bytes(state_q);
  assign BUSY       = accepts_bytes(state_q);
  assign DONE       = (state_q == ST_DONE);
  assign ERROR      = (state_q == ST_ERR);
  assign CPU_RST_N  = (state_q == ST_DONE);
  assign IM_WE      = im_we_q;
  assign IM_ADDR    = im_addr_q;
  assign IM_WD      = im_wd_q;

  assign byte_fire  = BYTE_VALID && BYTE_READY;
  assign start_fire = START && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign asm_valid  = byte_fire && (state_q == ST_DATA);

  word_assembler #(
    .WORD_BYTES(BPW)
  ) u_word_assembler (
    .clk       (CLK),
    .rst_n     (RST),
    .clear     (start_fire),
    .byte_in   (BYTE_IN),
    .byte_valid(asm_valid),
    .word_out  (asm_word),
    .word_valid(asm_word_valid)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    chk_d      = chk_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wd_d    = im_wd_q;
    len_lo_val = {len_q[LEN_W-1:8], BYTE_IN};

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (START) begin
          state_d    = ST_LEN_HI;
          len_d      = '0;
          word_cnt_d = '0;
          chk_d      = '0;
        end
      end
      ST_LEN_HI: begin
        if (byte_fire) begin
          len_d   = {BYTE_IN, len_q[7:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (byte_fire) begin
          len_d = len_lo_val;
          if (len_lo_val == '0 || 32'(len_lo_val) > 32'(MAX_WORDS)) state_d = ST_ERR;
          else                                                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_fire) begin
          chk_d = chk_update(chk_q, BYTE_IN);
          // Leave DATA as the last word is issued, so a byte arriving during
          // the write cycle is taken as the checksum.
          if (asm_word_valid) begin
            im_we_d    = 1'b1;
            im_addr_d  = INST_WIDTH'(word_cnt_q) << ADDR_SHIFT;
            im_wd_d    = asm_word;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_d == len_q) state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (byte_fire) state_d = (BYTE_IN == chk_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      chk_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wd_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      chk_q      <= chk_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wd_q    <= im_wd_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader with a stream-level model
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int MAX_WORDS = 256;
  localparam logic [7:0] PROG_A [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                          8'hAC, 8'h08, 8'h00, 8'h00};

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  BYTE_IN = 8'h00;
  logic        BYTE_VALID = 1'b0;
  logic        BYTE_READY, IM_WE, CPU_RST_N, BUSY, DONE, ERROR;
  logic [31:0] IM_ADDR, IM_WD;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] obs_addr[$], obs_data[$];
  logic        prev_we = 1'b0;
  int          exp_status;
  logic [7:0]  model_xor;

  prog_loader #(.INST_WIDTH(32), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .IM_WE(IM_WE), .IM_ADDR(IM_ADDR), .IM_WD(IM_WD),
    .CPU_RST_N(CPU_RST_N), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-cycle comparison of the write port against the model's expected writes.
  task automatic cycle_compare();
    logic [31:0] ea, ed;
    if (!RST) begin
      prev_we = 1'b0;
      return;
    end
    if (IM_WE) begin
      obs_addr.push_back(IM_ADDR);
      obs_data.push_back(IM_WD);
      check("we_single_cycle", {31'b0, prev_we}, 32'd0);
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required no write", IM_ADDR, IM_WD);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("write_addr", IM_ADDR, ea);
        check("write_data", IM_WD, ed);
      end
    end
    check("cpu_rst_only_in_done", {31'b0, CPU_RST_N}, {31'b0, DONE});
    check("busy_matches_ready", {31'b0, BUSY}, {31'b0, BYTE_READY});
    check("done_error_exclusive", {31'b0, DONE & ERROR}, 32'd0);
    prev_we = IM_WE;
  endtask

  task automatic tick(output logic rdy);
    @(negedge CLK);
    cycle_compare();
    rdy = BYTE_READY;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   waited;
    BYTE_VALID = 1'b0;
    repeat (gap) tick(rdy);
    BYTE_IN    = b;
    BYTE_VALID = 1'b1;
    waited     = 0;
    do begin
      tick(rdy);
      waited++;
    end while (!rdy && waited < 50);
    check("byte_accept", {31'b0, rdy}, 32'd1);
    BYTE_VALID = 1'b0;
  endtask

  // Expected writes and outcome of sending the first count bytes of stream.
  task automatic model_load(input int count);
    int n, base;
    exp_status = 0;
    model_xor  = 8'h00;
    if (count < 2) return;
    n = 256 * int'(stream[0]) + int'(stream[1]);
    if (n == 0 || n > MAX_WORDS) begin
      exp_status = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      base = 2 + 4 * k;
      if (base + 3 < count) begin
        exp_addr.push_back(32'(4 * k));
        exp_data.push_back({stream[base], stream[base+1], stream[base+2], stream[base+3]});
      end
    end
    for (int i = 2; i < 2 + 4 * n && i < count; i++) model_xor ^= stream[i];
    if (count > 2 + 4 * n) exp_status = (stream[2 + 4 * n] == model_xor) ? 1 : 2;
  endtask

  task automatic run_load(input string tag, input int gap, input int start_mid, input int count);
    logic rdy;
    model_load(count);
    obs_addr.delete();
    obs_data.delete();
    START = 1'b1;
    tick(rdy);
    START = 1'b0;
    check({tag, "_after_start"}, {28'b0, BUSY, DONE, ERROR, CPU_RST_N}, 32'h8);
    for (int i = 0; i < count; i++) begin
      if (i == start_mid) begin
        START = 1'b1;
        tick(rdy);
        START = 1'b0;
      end
      send_byte(stream[i], gap);
    end
    if (exp_status != 0) begin
      check({tag, "_status_on_last_byte"}, {30'b0, DONE, ERROR}, (exp_status == 1) ? 32'd2 : 32'd1);
      repeat (2) tick(rdy);
      check({tag, "_final_status"}, {28'b0, BUSY, DONE, ERROR, CPU_RST_N},
            (exp_status == 1) ? 32'h5 : 32'h2);
      check({tag, "_writes_outstanding"}, exp_addr.size(), 32'd0);
    end
  endtask

  task automatic load_prog_a(input logic [7:0] chk);
    stream.delete();
    for (int i = 0; i < 10; i++) stream.push_back(PROG_A[i]);
    stream.push_back(chk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {26'b0, CPU_RST_N, IM_WE, BYTE_READY, BUSY, DONE, ERROR}, 32'd0);
    check({tag, "_im_addr"}, IM_ADDR, 32'd0);
    check({tag, "_im_wd"}, IM_WD, 32'd0);
  endtask

  task automatic check_prog_a_writes(input string tag);
    check({tag, "_n_writes"}, obs_addr.size(), 32'd2);
    if (obs_addr.size() == 2) begin
      check({tag, "_addr0"}, obs_addr[0], 32'h0);
      check({tag, "_data0"}, obs_data[0], 32'h20080005);
      check({tag, "_addr1"}, obs_addr[1], 32'h4);
      check({tag, "_data1"}, obs_data[1], 32'hAC080000);
    end
  endtask

  initial begin
    logic       rdy;
    logic [7:0] b, x;

    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check_reset_outputs("in_reset");
    RST = 1'b1;
    repeat (2) tick(rdy);
    check("idle_ctrl", {26'b0, CPU_RST_N, IM_WE, BYTE_READY, BUSY, DONE, ERROR}, 32'd0);

    // XOR of the eight data bytes of program A is 0x89.
    load_prog_a(8'h89);
    run_load("basic", 0, -1, stream.size());
    check("basic_model_xor", {24'b0, model_xor}, 32'h89);
    check_prog_a_writes("basic");
    check("basic_done_literal", {29'b0, DONE, ERROR, CPU_RST_N}, 32'h5);
    check("basic_addr_held", IM_ADDR, 32'h4);
    check("basic_wd_held", IM_WD, 32'hAC080000);

    load_prog_a(8'h00);
    run_load("bad_chk", 0, -1, stream.size());
    check_prog_a_writes("bad_chk");
    check("bad_chk_error_literal", {29'b0, DONE, ERROR, CPU_RST_N}, 32'h2);

    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    run_load("hdr_zero", 0, -1, 2);
    check("hdr_zero_no_writes", obs_addr.size(), 32'd0);

    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h01);
    run_load("hdr_257", 0, -1, 2);
    check("hdr_257_no_writes", obs_addr.size(), 32'd0);

    load_prog_a(8'h89);
    run_load("gapped", 3, -1, stream.size());
    check_prog_a_writes("gapped");

    load_prog_a(8'h89);
    run_load("start_mid", 0, 5, stream.size());
    check_prog_a_writes("start_mid");

    load_prog_a(8'h89);
    run_load("abort", 0, -1, 8);
    RST = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    check("abort_first_word_kept", obs_addr.size(), 32'd1);
    check("abort_writes_outstanding", exp_addr.size(), 32'd0);
    repeat (2) tick(rdy);
    RST = 1'b1;
    repeat (3) tick(rdy);
    check("abort_waits_idle", {26'b0, CPU_RST_N, IM_WE, BYTE_READY, BUSY, DONE, ERROR}, 32'd0);
    load_prog_a(8'h89);
    run_load("after_abort", 0, -1, stream.size());
    check_prog_a_writes("after_abort");

    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    x = 8'h00;
    for (int i = 0; i < 4 * MAX_WORDS; i++) begin
      b = 8'($urandom_range(0, 255));
      stream.push_back(b);
      x ^= b;
    end
    stream.push_back(x);
    run_load("max_words", 0, -1, stream.size());
    check("max_words_n_writes", obs_addr.size(), 32'd256);
    if (obs_addr.size() == 256) check("max_words_last_addr", obs_addr[255], 32'h3FC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
